// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: streams instruction words into the instruction ROM while
// holding the core in reset, waits a settle period, then hands the ROM port to the core.
module boot_loader_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] cpu_rom_addr,
  input  logic              cpu_rom_we,
  input  logic              cpu_rom_re,
  input  logic [DATA_W-1:0] cpu_rom_din,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_we,
  output logic              rom_re,
  output logic [DATA_W-1:0] rom_din
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  localparam int                 SET_W       = $clog2(SETTLE_CYCLES + 2);
  localparam logic [ADDR_W-1:0]  PTR_MAX     = '1;
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [ADDR_W:0]   count_q, count_d;

  // State, write pointer, settle counter and word count registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      settle_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      settle_q <= settle_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic; the top ROM address acts as an implicit last word
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    settle_d = settle_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          count_d = count_q + (ADDR_W + 1)'(1);
          if (ld_last || (ptr_q == PTR_MAX)) begin
            settle_d = '0;
            if (SETTLE_CYCLES == 0) begin
              state_d = S_RUN;
            end else begin
              state_d = S_SETTLE;
            end
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; the core owns the ROM port only in RUN
  always_comb begin
    ld_ready  = 1'b0;
    cpu_reset = 1'b1;
    busy      = 1'b0;
    done      = 1'b0;
    rom_addr  = '0;
    rom_we    = 1'b0;
    rom_re    = 1'b0;
    rom_din   = '0;
    case (state_q)
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) begin
          rom_we   = 1'b1;
          rom_addr = ptr_q;
          rom_din  = ld_data;
        end else begin
          rom_we   = 1'b0;
        end
      end
      S_SETTLE: busy = 1'b1;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        rom_addr  = cpu_rom_addr;
        rom_we    = cpu_rom_we;
        rom_re    = cpu_rom_re;
        rom_din   = cpu_rom_din;
      end
      default: cpu_reset = 1'b1;
    endcase
  end

  assign word_count = count_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed self-checking bench for boot_loader_ctrl (ADDR_W=8, DATA_W=16, SETTLE_CYCLES=3).
module tb_boot_loader_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, ld_valid, ld_last, ld_ready;
  logic [15:0] ld_data;
  logic        cpu_reset, busy, done;
  logic [8:0]  word_count;
  logic [7:0]  cpu_rom_addr, rom_addr;
  logic        cpu_rom_we, cpu_rom_re, rom_we, rom_re;
  logic [15:0] cpu_rom_din, rom_din;

  int tests = 0;
  int failed = 0;

  boot_loader_ctrl #(.ADDR_W(8), .DATA_W(16), .SETTLE_CYCLES(3)) dut (
    .clock(clock), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .word_count(word_count),
    .cpu_rom_addr(cpu_rom_addr), .cpu_rom_we(cpu_rom_we), .cpu_rom_re(cpu_rom_re),
    .cpu_rom_din(cpu_rom_din),
    .rom_addr(rom_addr), .rom_we(rom_we), .rom_re(rom_re), .rom_din(rom_din)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One loader handshake: checks the ROM write presented in the same cycle
  task automatic push(input logic [15:0] data, input logic last, input logic [7:0] exp_addr);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
    #1;
    chk("hs_ready", {31'd0, ld_ready}, 32'd1);
    chk("hs_we", {31'd0, rom_we}, 32'd1);
    chk("hs_addr", {24'd0, rom_addr}, {24'd0, exp_addr});
    chk("hs_din", {16'd0, rom_din}, {16'd0, data});
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 16'h0000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // After the last-handshake edge: three SETTLE cycles, then RUN
  task automatic settle_to_run(input logic [8:0] exp_count);
    chk("settle_busy", {31'd0, busy}, 32'd1);
    chk("settle_ready", {31'd0, ld_ready}, 32'd0);
    chk("settle_count", {23'd0, word_count}, {23'd0, exp_count});
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("settle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    end
    tick();
    chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("run_done", {31'd0, done}, 32'd1);
    chk("run_busy", {31'd0, busy}, 32'd0);
    chk("run_count", {23'd0, word_count}, {23'd0, exp_count});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 16'h0000;
    cpu_rom_addr = 8'h00; cpu_rom_we = 1'b0; cpu_rom_re = 1'b0; cpu_rom_din = 16'h0000;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, rom_we}, 32'd0);
    chk("rst_re", {31'd0, rom_re}, 32'd0);
    chk("rst_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_din", {16'd0, rom_din}, 32'd0);
    chk("rst_count", {23'd0, word_count}, 32'd0);

    // 1: five back-to-back words
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 5; i++) push(16'h1121 + 16'(i), (i == 4), 8'(i));
    settle_to_run(9'd5);

    // 4a: ROM port passthrough in RUN
    cpu_rom_addr = 8'h03; cpu_rom_re = 1'b1; cpu_rom_din = 16'hBEEF;
    #1;
    chk("t4_addr", {24'd0, rom_addr}, 32'h03);
    chk("t4_re", {31'd0, rom_re}, 32'd1);
    chk("t4_din", {16'd0, rom_din}, 32'hBEEF);
    chk("t4_we0", {31'd0, rom_we}, 32'd0);
    cpu_rom_we = 1'b1;
    #1;
    chk("t4_we1", {31'd0, rom_we}, 32'd1);
    cpu_rom_we = 1'b0; cpu_rom_re = 1'b0;

    // 5: restart from RUN, with core traffic that must be ignored during LOAD (4b)
    pulse_start();
    chk("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("t5_ready", {31'd0, ld_ready}, 32'd1);
    chk("t5_count", {23'd0, word_count}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    cpu_rom_we = 1'b1; cpu_rom_re = 1'b1; cpu_rom_addr = 8'h10;
    #1;
    chk("t4b_we_idle", {31'd0, rom_we}, 32'd0);
    chk("t4b_re_idle", {31'd0, rom_re}, 32'd0);
    push(16'hA000, 1'b0, 8'h00);
    push(16'hA001, 1'b1, 8'h01);
    cpu_rom_we = 1'b0; cpu_rom_re = 1'b0; cpu_rom_addr = 8'h00;
    settle_to_run(9'd2);

    // 2: alternate-cycle valid, stray ld_last and start ignored while idle in LOAD
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      ld_last = 1'b1;
      start   = 1'b1;
      #1;
      chk("t2_gap_we", {31'd0, rom_we}, 32'd0);
      tick();
      ld_last = 1'b0;
      start   = 1'b0;
      chk("t2_gap_ready", {31'd0, ld_ready}, 32'd1);
      chk("t2_gap_count", {23'd0, word_count}, 32'(i));
      push(16'h2200 + 16'(i), (i == 4), 8'(i));
    end
    settle_to_run(9'd5);

    // 3: 256 words, no ld_last; the top address ends the load
    pulse_start();
    for (int i = 0; i < 256; i++) push(16'(i) ^ 16'h5A5A, 1'b0, 8'(i));
    chk("t3_count", {23'd0, word_count}, 32'd256);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    #1;
    chk("t3_extra_ready", {31'd0, ld_ready}, 32'd0);
    chk("t3_extra_we", {31'd0, rom_we}, 32'd0);
    tick();
    ld_valid = 1'b0;
    tick();
    tick();
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_count_run", {23'd0, word_count}, 32'd256);

    // 6: reset mid-LOAD, then reload from address 0, then reset mid-SETTLE
    pulse_start();
    push(16'h3000, 1'b0, 8'h00);
    push(16'h3001, 1'b0, 8'h01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("t6_ready", {31'd0, ld_ready}, 32'd0);
    chk("t6_count", {23'd0, word_count}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    push(16'h3100, 1'b1, 8'h00);
    chk("t6_settle_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6s_busy", {31'd0, busy}, 32'd0);
    chk("t6s_count", {23'd0, word_count}, 32'd0);
    tick();
    chk("t6s_idle_done", {31'd0, done}, 32'd0);
    chk("t6s_idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
